// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
interface inst_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // Loader side: consumes bytes, drives memory writes.
  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

  // Environment side: byte source and instruction memory.
  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction loader: 16-bit word-count header, then big-endian
// 32-bit words written to instruction memory from byte address 0. The core
// is held off until the load completes.
module inst_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                clk_CPU,
  input  logic                rst_CPU,
  inst_loader_if.master       bus,
  input  logic                start,
  output logic                cpu_run,
  output logic                load_err,
  output logic [15:0]         words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_BYTES,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic              in_ready_q, in_ready_d;
  logic              im_we_q, im_we_d;
  logic              cpu_run_q, cpu_run_d;
  logic              load_err_q, load_err_d;

  logic              xfer;
  logic [15:0]       hdr;
  logic [15:0]       words_inc;

  assign xfer      = bus.in_valid && in_ready_q;
  assign hdr       = {count_q[15:8], bus.in_data};
  assign words_inc = words_q + 16'd1;

  assign bus.in_ready = in_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = word_q;
  assign cpu_run      = cpu_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

  // Next-state logic; status outputs are decoded from the next state so
  // they become registered copies of the state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    words_d = words_q;

    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          count_d = {bus.in_data, count_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          count_d = hdr;
          idx_d   = 2'd0;
          addr_d  = '0;
          if (hdr == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, hdr} > DEPTH) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_BYTES;
          end
        end
      end
      S_BYTES: begin
        if (xfer) begin
          word_d = {word_q[23:0], bus.in_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        addr_d  = addr_q + ADDR_W'(4);
        idx_d   = 2'd0;
        state_d = (words_inc == count_q) ? S_DONE : S_BYTES;
      end
      S_DONE: begin
        if (start) begin
          words_d = 16'd0;
          addr_d  = '0;
          state_d = S_LEN_HI;
        end
      end
      S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
        end
      end
      default: state_d = S_LEN_HI;
    endcase

    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_BYTES);
    im_we_d    = (state_d == S_WRITE);
    cpu_run_d  = (state_d == S_DONE);
    load_err_d = (state_d == S_ERROR);
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      state_q    <= S_LEN_HI;
      count_q    <= 16'd0;
      word_q     <= 32'd0;
      idx_q      <= 2'd0;
      addr_q     <= '0;
      words_q    <= 16'd0;
      in_ready_q <= 1'b1;
      im_we_q    <= 1'b0;
      cpu_run_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      cpu_run_q  <= cpu_run_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the MIPS core's instruction memory.
- Receives a byte stream: a 16-bit word-count header followed by that many 32-bit instructions.
- Writes the words into instruction memory at consecutive word-aligned byte addresses from 0.
- Holds the core stalled until loading completes, then asserts cpu_run; replaces $readmemb preloading in system-level runs.

Parameters:
- ADDR_W, 10: instruction memory byte-address width.
- DEPTH, 256: instruction memory capacity in 32-bit words; must not exceed 2^(ADDR_W-2).

Ports:
- clk_CPU  input  1  system clock, rising edge.
- rst_CPU  input  1  asynchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- start  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
- im_we  output  1  instruction memory write enable, one cycle per word.
- im_addr  output  ADDR_W  byte address, multiple of 4.
- im_wdata  output  32  instruction word.
- cpu_run  output  1  core enable; high only in DONE.
- load_err  output  1  header exceeded DEPTH.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset: one clock, clk_CPU; reset rst_CPU is asynchronous and active-high. While rst_CPU is high, all state clears immediately, independent of the clock.
- Reset values: state=LEN_HI; in_ready=1; im_we=0; im_addr=0; im_wdata=0; cpu_run=0; load_err=0; words_loaded=0.
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is combinational from state only, never from in_valid.
- LEN_HI: on transfer, store the byte as count[15:8], go to LEN_LO.
- LEN_LO: on transfer, store the byte as count[7:0]. Next state from the full 16-bit count:
  - count==0 -> DONE.
  - count>DEPTH -> ERROR.
  - otherwise -> BYTES, with byte index=0 and word address=0.
- BYTES: assembles the word big-endian; the first byte goes to bits [31:24]. On the 4th transfer, go to WRITE.
- WRITE: lasts one cycle.
  - in_ready=0; im_we=1; im_addr=current address; im_wdata=assembled word.
  - At the edge ending WRITE: words_loaded+=1, address+=4.
  - If words_loaded (new value) == count -> DONE, else -> BYTES.
- Write latency: im_we is asserted in the cycle after the edge that accepted the 4th byte. Minimum spacing between writes is 5 cycles.
- DONE: in_ready=0; cpu_run=1.
  - A start pulse -> LEN_HI. The same edge clears cpu_run, words_loaded and the address.
- ERROR: in_ready=0; load_err=1; cpu_run=0; no writes.
  - start -> LEN_HI and clears load_err.
- start in any other state is ignored.
- in_valid with in_ready=0 is not consumed. The source must hold the byte.
- Address never wraps: count<=DEPTH guarantees the last address is 4*(DEPTH-1).
- cpu_run is registered and changes only on clock edges, except on reset.
- Reset mid-load: immediately aborts. Partial words are discarded; memory contents already written are left as is.

Test Plan:
- Header 0x00,0x02, then bytes 20,08,00,05 / 01,09,50,20 with in_valid held high:
  - im_we pulses twice: addr 0 data 0x20080005, then addr 4 data 0x01095020.
  - cpu_run rises on the edge after the second write; words_loaded=2.
- Header 0x00,0x00 -> DONE immediately after LEN_LO; cpu_run=1; im_we never asserted.
- Header 0x01,0x01 (257 > DEPTH=256):
  - load_err=1, cpu_run=0, in_ready=0.
  - A start pulse clears load_err and returns in_ready to 1.
- Gapped in_valid (one byte every 3 cycles), count=1, bytes AA,BB,CC,DD:
  - Exactly one write, data 0xAABBCCDD at addr 0.
  - No byte is consumed during the WRITE cycle.
- rst_CPU asserted between the 2nd and 3rd byte of word 1 of a 3-word load:
  - Outputs return to reset values without waiting for a clock edge.
  - A subsequent 1-word load writes to addr 0.
- In DONE after a 2-word load, pulse start and then send a 1-word load 0x8C, 0x08, 0x00, 0x00:
  - cpu_run drops on the start edge.
  - One write at addr 0 with data 0x8C080000.
  - cpu_run=1 again and words_loaded=1.
